// File: rtl/cpu_pkg.sv
// Shared types and constants for the PC / exception datapath.
// Consumed by pc_exception_unit and branch_cond.
package cpu_pkg;

    typedef enum logic [2:0] {IDLE, SAVE, FETCH, WAIT, LOAD} excState_t;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;
    localparam logic [1:0] CAUSE_ALIGN  = 2'd3;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_LE = 2'b10;
    localparam logic [1:0] BR_GT = 2'b11;

    // Priority pick; falls through to ALIGN only when no explicit request is present.
    function automatic logic [1:0] selectCause(input logic opc, input logic ovf,
                                               input logic div0);
        if (opc)       return CAUSE_OPCODE;
        else if (ovf)  return CAUSE_OVF;
        else if (div0) return CAUSE_DIV0;
        else           return CAUSE_ALIGN;
    endfunction

endpackage

// File: rtl/pc_exception_unit_if.sv
// Bus between the PC source mux / memory side and the PC exception unit.
// master drives requests and memory data; slave (the unit) drives PC state.
interface pc_exception_unit_if;

    logic [31:0] pc_next;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  branch_type;
    logic        alu_zero;
    logic        alu_gt;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [7:0]  mem_rdata;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [31:0] vec_addr;
    logic        vec_rd;
    logic        exc_busy;

    modport master (
        output pc_next, pc_write, pc_write_cond, branch_type, alu_zero, alu_gt,
               exc_opcode, exc_overflow, exc_div0, mem_rdata,
        input  pc, epc, cause, vec_addr, vec_rd, exc_busy
    );

    modport slave (
        input  pc_next, pc_write, pc_write_cond, branch_type, alu_zero, alu_gt,
               exc_opcode, exc_overflow, exc_div0, mem_rdata,
        output pc, epc, cause, vec_addr, vec_rd, exc_busy
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch-taken decode from the ALU flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [1:0] branchType,
    input  logic       aluZero,
    input  logic       aluGt,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (branchType)
            BR_EQ:   taken = aluZero;
            BR_NE:   taken = !aluZero;
            BR_LE:   taken = !aluGt;
            BR_GT:   taken = aluGt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_exception_unit.sv
// Architectural PC, EPC and cause registers plus the exception vector-fetch sequencer.
// Optional misaligned-PC-write exception enabled by defining PC_ALIGN_CHECK_EN.
module pc_exception_unit
    import cpu_pkg::*;
#(
    parameter int unsigned VEC_BASE = 253,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_exception_unit_if.slave   bus
);

    excState_t   stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [31:0] epcQ, epcD;
    logic [1:0]  causeQ, causeD;
    logic [31:0] vecAddrQ, vecAddrD;
    logic [2:0]  cntQ, cntD;
    logic [7:0]  vecByteQ, vecByteD;

    logic taken;
    logic writeQual;
    logic alignExc;
    logic excAny;

    branch_cond uBranchCond (
        .branchType (bus.branch_type),
        .aluZero    (bus.alu_zero),
        .aluGt      (bus.alu_gt),
        .taken      (taken)
    );

    assign writeQual = bus.pc_write || (bus.pc_write_cond && taken);

`ifdef PC_ALIGN_CHECK_EN
    assign alignExc = writeQual && (bus.pc_next[1:0] != 2'b00);
`else
    assign alignExc = 1'b0;
`endif

    assign excAny = bus.exc_opcode || bus.exc_overflow || bus.exc_div0 || alignExc;

    always_comb begin
        stateD   = stateQ;
        pcD      = pcQ;
        epcD     = epcQ;
        causeD   = causeQ;
        vecAddrD = vecAddrQ;
        cntD     = cntQ;
        vecByteD = vecByteQ;
        unique case (stateQ)
            IDLE: begin
                // An exception request suppresses any PC write in the same cycle.
                if (excAny) begin
                    causeD = selectCause(bus.exc_opcode, bus.exc_overflow, bus.exc_div0);
                    stateD = SAVE;
                end else if (writeQual) begin
                    pcD = bus.pc_next;
                end
            end
            SAVE: begin
                epcD     = pcQ - 32'd4;
                vecAddrD = 32'(VEC_BASE) + {30'b0, causeQ};
                stateD   = FETCH;
            end
            FETCH: begin
                cntD   = 3'(MEM_LAT);
                stateD = WAIT;
            end
            WAIT: begin
                cntD = cntQ - 3'd1;
                // <= 1 rather than == 1 so a zero count can never strand the FSM.
                if (cntQ <= 3'd1) begin
                    cntD     = 3'd0;
                    vecByteD = bus.mem_rdata;
                    stateD   = LOAD;
                end
            end
            LOAD: begin
                pcD    = {24'b0, vecByteQ};
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= IDLE;
            pcQ      <= 32'd0;
            epcQ     <= 32'd0;
            causeQ   <= 2'd0;
            vecAddrQ <= 32'd0;
            cntQ     <= 3'd0;
            vecByteQ <= 8'd0;
        end else begin
            stateQ   <= stateD;
            pcQ      <= pcD;
            epcQ     <= epcD;
            causeQ   <= causeD;
            vecAddrQ <= vecAddrD;
            cntQ     <= cntD;
            vecByteQ <= vecByteD;
        end
    end

    assign bus.pc       = pcQ;
    assign bus.epc      = epcQ;
    assign bus.cause    = causeQ;
    assign bus.vec_addr = vecAddrQ;
    assign bus.vec_rd   = (stateQ == FETCH);
    assign bus.exc_busy = (stateQ != IDLE);

endmodule
